// File: rtl/div_unit_pkg.sv
// Shared divider constants: widths, FSM encodings and sign helpers.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  // Two's-complement negate when en is set.
  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic en,
                                                  input logic [DIV_WIDTH-1:0] x);
    return en ? DIV_WIDTH'(~x + 1'b1) : x;
  endfunction

  // Magnitude of x when treated as signed (en=1), else x unchanged.
  function automatic logic [DIV_WIDTH-1:0] mag_if(input logic en,
                                                  input logic [DIV_WIDTH-1:0] x);
    return neg_if(en & x[DIV_WIDTH-1], x);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Pipeline <-> divider bundle: E-stage operands in, stall/result out.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                 startE;
  logic                 signedE;
  logic [DIV_WIDTH-1:0] srcaE;
  logic [DIV_WIDTH-1:0] srcbE;
  logic                 cancel;
  logic                 div_stallE;
  logic                 div_valid;
  logic [DIV_WIDTH-1:0] div_hi;
  logic [DIV_WIDTH-1:0] div_lo;

  modport master (
    output startE, signedE, srcaE, srcbE, cancel,
    input  div_stallE, div_valid, div_hi, div_lo
  );

  modport slave (
    input  startE, signedE, srcaE, srcbE, cancel,
    output div_stallE, div_valid, div_hi, div_lo
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration (combinational).
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic                 dvd_bit_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIV_WIDTH:0] shifted_c;

  // Shift in the next dividend bit and subtract the divisor if it fits.
  always_comb begin
    shifted_c = {rem_i, dvd_bit_i};
    if (shifted_c >= {1'b0, dvs_i}) begin
      q_bit_o = 1'b1;
      rem_o   = DIV_WIDTH'(shifted_c - {1'b0, dvs_i});
    end else begin
      q_bit_o = 1'b0;
      rem_o   = shifted_c[DIV_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the E stage: stalls the pipe while iterating,
// pulses div_valid once with quotient on div_lo and remainder on div_hi.
module div_unit
  import div_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  div_unit_if.slave      div_if
);

  localparam int unsigned WIDTH = DIV_WIDTH;
  localparam int unsigned CNT_W = DIV_CNT_W;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;   // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic             negq_q,  negq_d;
  logic             negr_q,  negr_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Next-state, datapath and output-load decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (div_if.startE) begin
          dvd_d  = mag_if(div_if.signedE, div_if.srcaE);
          dvs_d  = mag_if(div_if.signedE, div_if.srcbE);
          negq_d = div_if.signedE & (div_if.srcaE[WIDTH-1] ^ div_if.srcbE[WIDTH-1]);
          negr_d = div_if.signedE & div_if.srcaE[WIDTH-1];
          rem_d  = '0;
          cnt_d  = '0;
          if (div_if.srcbE == '0) begin
            // Divide by zero: raw dividend to HI, all-ones to LO, no iteration.
            state_d = DIV_DONE;
            hi_d    = div_if.srcaE;
            lo_d    = '1;
            valid_d = 1'b1;
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_DONE;
          hi_d    = neg_if(negr_q, step_rem);
          lo_d    = neg_if(negq_q, {dvd_q[WIDTH-2:0], step_q});
          valid_d = 1'b1;
        end
      end
      DIV_DONE: begin
        // Same instruction is still in E; startE is ignored here.
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // A kill abandons the divide without touching the results.
    if (div_if.cancel) begin
      state_d = DIV_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      valid_d = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
    end
  end

  // Stall is combinational so the start cycle itself holds the pipe.
  assign div_if.div_stallE = (((state_q == DIV_IDLE) & div_if.startE) |
                              (state_q == DIV_BUSY)) & ~div_if.cancel;
  assign div_if.div_valid  = valid_q;
  assign div_if.div_hi     = hi_q;
  assign div_if.div_lo     = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, overflow case, cancel, reset mid-divide and back-to-back divides.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if dif ();

  div_unit u_dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a divide and run until the valid pulse (bounded). Returns with
  // startE still high, sampled inside the DONE cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int stalls, output int lat, output int vcyc);
    @(negedge clk);
    dif.startE  = 1'b1;
    dif.signedE = s;
    dif.srcaE   = a;
    dif.srcbE   = b;
    stalls = 0;
    lat    = 0;
    vcyc   = -1;
    for (int i = 0; i < 45; i++) begin
      #1;
      if (dif.div_valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
      if (dif.div_stallE === 1'b1) stalls++;
      lat++;
      @(negedge clk);
    end
  endtask

  // Drop startE after DONE; the held instruction must not restart.
  task automatic retire(input string tag);
    @(negedge clk);
    dif.startE = 1'b0;
    #1;
    check({tag, " valid 1 cycle"}, 32'(dif.div_valid), 32'd0);
    check({tag, " no restart"},    32'(dif.div_stallE), 32'd0);
  endtask

  initial begin
    int st, lt, vc, v1, nvalid;

    rst         = 1'b1;
    dif.startE  = 1'b0;
    dif.signedE = 1'b0;
    dif.srcaE   = '0;
    dif.srcbE   = '0;
    dif.cancel  = 1'b0;
    #1;
    check("reset hi",    dif.div_hi, 32'd0);
    check("reset lo",    dif.div_lo, 32'd0);
    check("reset valid", 32'(dif.div_valid), 32'd0);
    check("reset stall", 32'(dif.div_stallE), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7
    do_div(32'd100, 32'd7, 1'b0, st, lt, vc);
    check("divu 100/7 stall cycles", 32'(st), 32'd33);
    check("divu 100/7 latency",      32'(lt), 32'd33);
    check("divu 100/7 stall in done", 32'(dif.div_stallE), 32'd0);
    check("divu 100/7 lo", dif.div_lo, 32'd14);
    check("divu 100/7 hi", dif.div_hi, 32'd2);
    retire("divu 100/7");

    // DIV -7/2
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, st, lt, vc);
    check("div -7/2 latency", 32'(lt), 32'd33);
    check("div -7/2 lo", dif.div_lo, 32'hFFFF_FFFD);
    check("div -7/2 hi", dif.div_hi, 32'hFFFF_FFFF);
    retire("div -7/2");

    // DIV 7/-2
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, st, lt, vc);
    check("div 7/-2 lo", dif.div_lo, 32'hFFFF_FFFD);
    check("div 7/-2 hi", dif.div_hi, 32'd1);
    retire("div 7/-2");

    // DIVU 5/0
    do_div(32'd5, 32'd0, 1'b0, st, lt, vc);
    check("divu 5/0 stall cycles", 32'(st), 32'd1);
    check("divu 5/0 latency",      32'(lt), 32'd1);
    check("divu 5/0 lo", dif.div_lo, 32'hFFFF_FFFF);
    check("divu 5/0 hi", dif.div_hi, 32'd5);
    retire("divu 5/0");

    // DIV -5/0: raw dividend regardless of signedness
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, st, lt, vc);
    check("div -5/0 lo", dif.div_lo, 32'hFFFF_FFFF);
    check("div -5/0 hi", dif.div_hi, 32'hFFFF_FFFB);
    retire("div -5/0");

    // DIV 0x8000_0000 / -1
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, st, lt, vc);
    check("div min/-1 latency", 32'(lt), 32'd33);
    check("div min/-1 lo", dif.div_lo, 32'h8000_0000);
    check("div min/-1 hi", dif.div_hi, 32'd0);
    retire("div min/-1");

    // Cancel in the 10th BUSY cycle
    @(negedge clk);
    dif.startE  = 1'b1;
    dif.signedE = 1'b0;
    dif.srcaE   = 32'd100;
    dif.srcbE   = 32'd7;
    #1;
    check("cancel start stall", 32'(dif.div_stallE), 32'd1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    dif.cancel = 1'b1;
    #1;
    check("cancel stall drops", 32'(dif.div_stallE), 32'd0);
    @(negedge clk);
    dif.cancel = 1'b0;
    dif.startE = 1'b0;
    #1;
    check("cancel idle next", 32'(dif.div_stallE), 32'd0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (dif.div_valid === 1'b1) nvalid++;
    end
    check("cancel no valid", 32'(nvalid), 32'd0);
    check("cancel lo held", dif.div_lo, 32'h8000_0000);
    check("cancel hi held", dif.div_hi, 32'd0);

    // cancel and startE together in IDLE
    @(negedge clk);
    dif.startE = 1'b1;
    dif.cancel = 1'b1;
    dif.srcaE  = 32'd9;
    dif.srcbE  = 32'd3;
    #1;
    check("start+cancel stall", 32'(dif.div_stallE), 32'd0);
    @(negedge clk);
    dif.startE = 1'b0;
    dif.cancel = 1'b0;
    #1;
    check("start+cancel idle", 32'(dif.div_stallE), 32'd0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (dif.div_valid === 1'b1) nvalid++;
    end
    check("start+cancel no valid", 32'(nvalid), 32'd0);
    check("start+cancel lo held", dif.div_lo, 32'h8000_0000);

    // Back-to-back: startE held through DONE, next instruction right after
    do_div(32'd100, 32'd7, 1'b0, st, lt, vc);
    v1 = vc;
    check("b2b first lo", dif.div_lo, 32'd14);
    check("b2b first hi", dif.div_hi, 32'd2);
    do_div(32'hFFFF_FFFF, 32'd16, 1'b0, st, lt, vc);
    check("b2b second stall cycles", 32'(st), 32'd33);
    check("b2b second lo", dif.div_lo, 32'h0FFF_FFFF);
    check("b2b second hi", dif.div_hi, 32'd15);
    check("b2b valid spacing", 32'(vc - v1), 32'd34);
    retire("b2b");

    // Reset mid-BUSY
    @(negedge clk);
    dif.startE = 1'b1;
    dif.srcaE  = 32'd100;
    dif.srcbE  = 32'd7;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    check("pre-reset busy stall", 32'(dif.div_stallE), 32'd1);
    rst        = 1'b1;
    dif.startE = 1'b0;
    #1;
    check("mid reset hi",    dif.div_hi, 32'd0);
    check("mid reset lo",    dif.div_lo, 32'd0);
    check("mid reset valid", 32'(dif.div_valid), 32'd0);
    check("mid reset stall", 32'(dif.div_stallE), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post reset stall", 32'(dif.div_stallE), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
